// File: rtl/reg_status_file_pkg.sv
// Shared widths, tag encoding and small helpers for the register status file.
// Consumed by reg_status_file and reg_read_port.
package reg_status_file_pkg;

    localparam int REG_NUM_WIDTH  = 5;
    localparam int COMMON_WIDTH   = 32;
    localparam int INST_TAG_WIDTH = 5;
    localparam int NUM_REGS       = 1 << REG_NUM_WIDTH;
    localparam int BUSY_WIDTH     = REG_NUM_WIDTH + 1;

    typedef logic [REG_NUM_WIDTH-1:0]  reg_idx_t;
    typedef logic [COMMON_WIDTH-1:0]   word_t;
    typedef logic [INST_TAG_WIDTH-1:0] tag_t;
    typedef logic [BUSY_WIDTH-1:0]     busy_t;

    // ROB tags occupy 0..15; bit 4 alone marks "no producer pending".
    localparam tag_t TAG_INVALID = 5'h10;

    function automatic logic tag_is_valid(input tag_t t);
        return t != TAG_INVALID;
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// One combinational operand read port: register-file mux with the r0 rule.
// Optional commit-to-read forwarding is selected by REGFILE_BYPASS_EN.
module reg_read_port
    import reg_status_file_pkg::*;
(
    input  logic [REG_NUM_WIDTH-1:0]  addr,
    input  logic [COMMON_WIDTH-1:0]   data_q [NUM_REGS],
    input  logic [INST_TAG_WIDTH-1:0] tag_q  [NUM_REGS],
    input  logic                      wb_en,
    input  logic [REG_NUM_WIDTH-1:0]  wb_rd,
    input  logic [COMMON_WIDTH-1:0]   wb_data,
    input  logic [INST_TAG_WIDTH-1:0] wb_tag,
    output logic [COMMON_WIDTH-1:0]   val,
    output logic [INST_TAG_WIDTH-1:0] tag
);

`ifdef REGFILE_BYPASS_EN
    logic fwd_hit;

    // Forward only a commit that would actually retire the current producer.
    assign fwd_hit = wb_en && (wb_rd == addr) && (addr != '0)
                     && tag_is_valid(wb_tag) && (tag_q[addr] == wb_tag);
`else
    logic unused_wb;

    assign unused_wb = ^{wb_en, wb_rd, wb_data, wb_tag};
`endif

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        val = data_q[addr];
        tag = tag_q[addr];
        if (addr == '0) begin
            val = '0;
            tag = TAG_INVALID;
        end
`ifdef REGFILE_BYPASS_EN
        if (fwd_hit) begin
            val = wb_data;
            tag = TAG_INVALID;
        end
`endif
    end

endmodule

// File: rtl/reg_status_file.sv
// Renamed register file: 32 data words plus a pending ROB tag per register.
// Define REGFILE_BYPASS_EN to forward same-cycle commits onto the read ports.
module reg_status_file
    import reg_status_file_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iss_en,
    input  logic [REG_NUM_WIDTH-1:0]  iss_rd,
    input  logic [INST_TAG_WIDTH-1:0] iss_tag,
    input  logic [REG_NUM_WIDTH-1:0]  rs1_addr,
    input  logic [REG_NUM_WIDTH-1:0]  rs2_addr,
    output logic [COMMON_WIDTH-1:0]   rs1_val,
    output logic [COMMON_WIDTH-1:0]   rs2_val,
    output logic [INST_TAG_WIDTH-1:0] rs1_tag,
    output logic [INST_TAG_WIDTH-1:0] rs2_tag,
    input  logic                      wb_en,
    input  logic [REG_NUM_WIDTH-1:0]  wb_rd,
    input  logic [COMMON_WIDTH-1:0]   wb_data,
    input  logic [INST_TAG_WIDTH-1:0] wb_tag,
    input  logic                      flush,
    output logic [BUSY_WIDTH-1:0]     busy_cnt
);

    word_t data_q [NUM_REGS];
    tag_t  tag_q  [NUM_REGS];
    word_t data_n [NUM_REGS];
    tag_t  tag_n  [NUM_REGS];
    busy_t busy_q;
    busy_t busy_n;

    logic issue_ok;
    logic commit_ok;

    // A TAG_INVALID tag on either port turns that operation into a no-op.
    assign issue_ok  = iss_en && tag_is_valid(iss_tag) && !flush;
    assign commit_ok = wb_en && tag_is_valid(wb_tag);

    // Priority per register: commit, then issue (younger rename wins), then flush.
    always_comb begin
        data_n = data_q;
        tag_n  = tag_q;
        busy_n = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (commit_ok && wb_rd == reg_idx_t'(i)) begin
                data_n[i] = wb_data;
                if (tag_q[i] == wb_tag) begin
                    tag_n[i] = TAG_INVALID;
                end
            end
            if (issue_ok && iss_rd == reg_idx_t'(i)) begin
                tag_n[i] = iss_tag;
            end
            if (flush) begin
                tag_n[i] = TAG_INVALID;
            end
            if (tag_is_valid(tag_n[i])) begin
                busy_n = busy_n + busy_t'(1);
            end
        end
    end

    // NOTE: the array is flops, not a RAM macro, so it is reset like any other
    // state; reads right after reset must return 0 / TAG_INVALID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= TAG_INVALID;
            end
            busy_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only.
            data_q <= data_n;
            tag_q  <= tag_n;
            busy_q <= busy_n;
        end
    end

    assign busy_cnt = busy_q;

    reg_read_port u_rs1 (
        .addr    (rs1_addr),
        .data_q  (data_q),
        .tag_q   (tag_q),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .wb_tag  (wb_tag),
        .val     (rs1_val),
        .tag     (rs1_tag)
    );

    reg_read_port u_rs2 (
        .addr    (rs2_addr),
        .data_q  (data_q),
        .tag_q   (tag_q),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .wb_tag  (wb_tag),
        .val     (rs2_val),
        .tag     (rs2_tag)
    );

endmodule

// File: tb/tb_reg_status_file.sv
// Self-checking bench for reg_status_file: directed vectors plus a short random
// phase, checked against a register/tag array model every cycle.
module tb_reg_status_file;

    localparam logic [4:0] TI = 5'h10;

    logic        clk;
    logic        rst;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_tag;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rs1_tag;
    logic [4:0]  rs2_tag;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;
    logic        flush;
    logic [5:0]  busy_cnt;

    int n_checks = 0;
    int n_errors = 0;

    reg_status_file dut (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .iss_tag  (iss_tag),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .rs1_tag  (rs1_tag),
        .rs2_tag  (rs2_tag),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .wb_tag   (wb_tag),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: what each register holds and who still owes it a value.
    logic [31:0] m_data [32];
    logic [4:0]  m_tag  [32];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] = 32'h0;
                m_tag[i]  = TI;
            end
        end else begin
            if (wb_en && wb_rd != 5'd0 && wb_tag != TI) begin
                m_data[wb_rd] = wb_data;
                if (m_tag[wb_rd] == wb_tag) m_tag[wb_rd] = TI;
            end
            if (iss_en && iss_rd != 5'd0 && iss_tag != TI) m_tag[iss_rd] = iss_tag;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_tag[i] = TI;
            end
        end
    end

    function automatic logic fwd(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        return wb_en && a != 5'd0 && wb_rd == a && wb_tag != TI && m_tag[a] == wb_tag;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_val(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (fwd(a)) return wb_data;
        return m_data[a];
    endfunction

    function automatic logic [4:0] exp_tag(input logic [4:0] a);
        if (a == 5'd0 || fwd(a)) return TI;
        return m_tag[a];
    endfunction

    function automatic int exp_busy();
        int n = 0;
        for (int i = 1; i < 32; i++) if (m_tag[i] != TI) n++;
        return n;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("model rs1_val", rs1_val, exp_val(rs1_addr));
            check("model rs1_tag", 32'(rs1_tag), 32'(exp_tag(rs1_addr)));
            check("model rs2_val", rs2_val, exp_val(rs2_addr));
            check("model rs2_tag", 32'(rs2_tag), 32'(exp_tag(rs2_addr)));
            check("model busy_cnt", 32'(busy_cnt), 32'(exp_busy()));
        end
    end

    task automatic idle();
        iss_en = 1'b0; iss_rd = 5'd0; iss_tag = 5'd0;
        wb_en = 1'b0;  wb_rd = 5'd0;  wb_data = 32'h0; wb_tag = 5'd0;
        flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] t);
        iss_en = 1'b1; iss_rd = rd; iss_tag = t;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [4:0] t, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = rd; wb_tag = t; wb_data = d;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        #2;
        check("reset rs1_val", rs1_val, 32'h0);
        check("reset rs1_tag", 32'(rs1_tag), 32'h10);
        check("reset busy", 32'(busy_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("r5 after reset val", rs1_val, 32'h0);
        check("r5 after reset tag", 32'(rs1_tag), 32'h10);

        // Rename r5, then commit it.
        issue(5'd5, 5'd3);
        #2 check("rename hidden same cycle", 32'(rs1_tag), 32'h10);
        step(); idle();
        #2 check("r5 pending tag", 32'(rs1_tag), 32'd3);
        check("busy one", 32'(busy_cnt), 32'd1);
        commit(5'd5, 5'd3, 32'hDEADBEEF);
        #2;
`ifdef REGFILE_BYPASS_EN
        check("r5 commit cycle tag", 32'(rs1_tag), 32'h10);
        check("r5 commit cycle val", rs1_val, 32'hDEADBEEF);
`else
        check("r5 commit cycle tag", 32'(rs1_tag), 32'd3);
        check("r5 commit cycle val", rs1_val, 32'h0);
`endif
        step(); idle();
        #2 check("r5 committed val", rs1_val, 32'hDEADBEEF);
        check("r5 committed tag", 32'(rs1_tag), 32'h10);
        check("busy zero", 32'(busy_cnt), 32'd0);

        // Older commit must not clear a younger rename.
        rs2_addr = 5'd7;
        issue(5'd7, 5'd2); step();
        issue(5'd7, 5'd9); step(); idle();
        commit(5'd7, 5'd2, 32'h11); step(); idle();
        #2 check("r7 data", rs2_val, 32'h11);
        check("r7 young tag", 32'(rs2_tag), 32'd9);
        check("busy r7", 32'(busy_cnt), 32'd1);

        // Same-cycle issue and commit: issue wins the tag.
        rs1_addr = 5'd4;
        issue(5'd4, 5'd1); step(); idle();
        issue(5'd4, 5'd6); commit(5'd4, 5'd1, 32'h55); step(); idle();
        #2 check("r4 data", rs1_val, 32'h55);
        check("r4 tag", 32'(rs1_tag), 32'd6);
        check("busy r4 r7", 32'(busy_cnt), 32'd2);

        // Flush with a same-cycle issue (dropped) and commit (data kept).
        issue(5'd1, 5'd7); step();
        issue(5'd2, 5'd8); step();
        issue(5'd3, 5'd10); step(); idle();
        #2 check("busy five", 32'(busy_cnt), 32'd5);
        flush = 1'b1; issue(5'd8, 5'd4); commit(5'd2, 5'd8, 32'hAB);
        step(); idle();
        rs1_addr = 5'd8; rs2_addr = 5'd2;
        #2 check("flush r8 tag", 32'(rs1_tag), 32'h10);
        check("flush r2 data", rs2_val, 32'hAB);
        check("flush r2 tag", 32'(rs2_tag), 32'h10);
        check("flush busy", 32'(busy_cnt), 32'd0);

        // Commit-to-read forwarding.
        rs1_addr = 5'd9;
        issue(5'd9, 5'd5); step(); idle();
        commit(5'd9, 5'd5, 32'h77);
        #2;
`ifdef REGFILE_BYPASS_EN
        check("r9 bypass val", rs1_val, 32'h77);
        check("r9 bypass tag", 32'(rs1_tag), 32'h10);
`else
        check("r9 no bypass tag", 32'(rs1_tag), 32'd5);
`endif
        step(); idle();
        #2 check("r9 val", rs1_val, 32'h77);

        // r0 ignores issue and commit.
        rs1_addr = 5'd0;
        issue(5'd0, 5'd3); commit(5'd0, 5'd1, 32'hFF); step(); idle();
        #2 check("r0 val", rs1_val, 32'h0);
        check("r0 tag", 32'(rs1_tag), 32'h10);
        check("r0 busy", 32'(busy_cnt), 32'd0);

        // TAG_INVALID on either port is a no-op.
        rs1_addr = 5'd10; rs2_addr = 5'd5;
        issue(5'd10, TI); commit(5'd5, TI, 32'h1234); step(); idle();
        #2 check("invalid iss tag", 32'(rs1_tag), 32'h10);
        check("invalid wb tag", rs2_val, 32'hDEADBEEF);

        // Reset mid-operation, then normal operation on the first edge after.
        rs1_addr = 5'd5; rs2_addr = 5'd11;
        issue(5'd11, 5'd1); commit(5'd5, 5'd0, 32'h99);
        #1 rst = 1'b1;
        #1 check("midrst r5 val", rs1_val, 32'h0);
        check("midrst busy", 32'(busy_cnt), 32'd0);
        step();
        rst = 1'b0; idle();
        rs1_addr = 5'd12;
        issue(5'd12, 5'd2); step(); idle();
        #2 check("post rst r12 tag", 32'(rs1_tag), 32'd2);
        check("post rst r11 tag", 32'(rs2_tag), 32'h10);
        check("post rst busy", 32'(busy_cnt), 32'd1);

        // Random traffic checked by the model every cycle.
        for (int n = 0; n < 400; n++) begin
            iss_en   = 1'($urandom_range(0, 1));
            iss_rd   = 5'($urandom);
            iss_tag  = ($urandom_range(0, 9) == 0) ? TI : 5'($urandom_range(0, 15));
            wb_en    = 1'($urandom_range(0, 1));
            wb_rd    = ($urandom_range(0, 1) == 0) ? iss_rd : 5'($urandom);
            wb_tag   = ($urandom_range(0, 9) == 0) ? TI : 5'($urandom_range(0, 15));
            wb_data  = $urandom;
            flush    = ($urandom_range(0, 15) == 0);
            rs1_addr = ($urandom_range(0, 2) == 0) ? wb_rd : 5'($urandom);
            rs2_addr = 5'($urandom);
            step();
        end
        idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
